// File: rtl/micro_pkg.sv
// Shared widths and loader state encoding for the micro core instruction store.
package micro_pkg;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 13;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_LO = 3'd1,
        LOAD_HI = 3'd2,
        CHECK   = 3'd3,
        FILL    = 3'd4,
        RUN     = 3'd5,
        ERROR   = 3'd6
    } ld_state_e;
endpackage

// File: rtl/prog_ram.sv
// Instruction RAM: synchronous write port, asynchronous read port for fetch.
module prog_ram
    import micro_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata_c
);
    logic [INST_W-1:0] mem [DEPTH];

    // Contents survive reset; unloaded words are cleared by the loader's fill pass.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header, word pairs, XOR checksum, zero fill, then run.
module prog_loader
    import micro_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  words_loaded
);
    ld_state_e         state, state_nx;
    logic [7:0]        hdr, lo, csum;
    logic [ADDR_W-1:0] waddr;
    logic              take, hdr_en, lo_en, word_en, fill_en, last_word;
    logic [CNT_W-1:0]  n_words;
    logic              ram_we;
    logic [INST_W-1:0] ram_wdata;

    // A dropped transfer under reload must not touch any state.
    assign take      = in_valid & in_ready & ~reload;
    assign n_words   = (hdr == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(hdr);
    assign last_word = ((words_loaded + CNT_W'(1)) == n_words);

    always_comb begin
        state_nx = state;
        hdr_en   = 1'b0;
        lo_en    = 1'b0;
        word_en  = 1'b0;
        fill_en  = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    hdr_en   = 1'b1;
                    state_nx = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (take) begin
                    lo_en    = 1'b1;
                    state_nx = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (take) begin
                    if (in_data[7:5] != 3'd0) begin
                        state_nx = ERROR;
                    end else begin
                        word_en  = 1'b1;
                        state_nx = last_word ? CHECK : LOAD_LO;
                    end
                end
            end
            CHECK: begin
                if (take) begin
                    if (in_data != csum)   state_nx = ERROR;
                    else if (hdr == 8'd0)  state_nx = RUN;
                    else                   state_nx = FILL;
                end
            end
            FILL: begin
                fill_en = ~reload;
                if (waddr == ADDR_W'(DEPTH - 1)) state_nx = RUN;
            end
            RUN:     state_nx = RUN;
            ERROR:   state_nx = ERROR;
            default: state_nx = IDLE;
        endcase
        if (reload) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE) || (state_nx == LOAD_LO) ||
                         (state_nx == LOAD_HI) || (state_nx == CHECK);
            cpu_reset <= (state_nx != RUN);
            done      <= (state_nx == RUN);
            error     <= (state_nx == ERROR);
        end
    end

    // Datapath: header, low-byte latch, running checksum, write address, word count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr          <= 8'd0;
            lo           <= 8'd0;
            csum         <= 8'd0;
            waddr        <= '0;
            words_loaded <= '0;
        end else if (reload) begin
            csum         <= 8'd0;
            waddr        <= '0;
            words_loaded <= '0;
        end else begin
            if (hdr_en) begin
                hdr          <= in_data;
                csum         <= in_data;
                waddr        <= '0;
                words_loaded <= '0;
            end
            if (lo_en) begin
                lo   <= in_data;
                csum <= csum ^ in_data;
            end
            if (word_en) begin
                csum         <= csum ^ in_data;
                waddr        <= waddr + ADDR_W'(1);
                words_loaded <= words_loaded + CNT_W'(1);
            end
            if (fill_en) waddr <= waddr + ADDR_W'(1);
        end
    end

    assign ram_we    = word_en | fill_en;
    assign ram_wdata = word_en ? INST_W'({in_data[4:0], lo}) : '0;

    prog_ram u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (waddr),
        .wdata   (ram_wdata),
        .raddr   (pc),
        .rdata_c (inst)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Directed checks of the program loader: load, fill, errors, reload and reset.
module tb_prog_loader;
    import micro_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  words_loaded;

    int passed = 0;
    int total  = 0;

    prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .pc           (pc),
        .inst         (inst),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_ready: in_ready stuck at %b for byte %h", in_ready, b);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL rst_error got %b exp 0", error); else passed++;
        total++; if (words_loaded !== 9'd0) $display("FAIL rst_words got %0d exp 0", words_loaded); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_load();
        int n;
        send(8'h02); send(8'h34); send(8'h12); send(8'hFF); send(8'h1F); send(8'hC4);
        total++; if (error !== 1'b0) $display("FAIL fill_error got %b exp 0", error); else passed++;
        total++; if (words_loaded !== 9'd2) $display("FAIL fill_words got %0d exp 2", words_loaded); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else passed++;
        total++; if (cpu_reset !== 1'b1) $display("FAIL fill_cpu_reset got %b exp 1", cpu_reset); else passed++;
        wait_done(n);
        total++; if (n !== 254) $display("FAIL fill_cycles got %0d exp 254", n); else passed++;
        total++; if (cpu_reset !== 1'b0) $display("FAIL run_cpu_reset got %b exp 0", cpu_reset); else passed++;
        pc = 8'h00; #1;
        total++; if (inst !== 13'h1234) $display("FAIL fetch_00 got %h exp 1234", inst); else passed++;
        pc = 8'h01; #1;
        total++; if (inst !== 13'h1FFF) $display("FAIL fetch_01 got %h exp 1fff", inst); else passed++;
        pc = 8'h02; #1;
        total++; if (inst !== 13'h0000) $display("FAIL fetch_02 got %h exp 0000", inst); else passed++;
        pc = 8'hFF; #1;
        total++; if (inst !== 13'h0000) $display("FAIL fetch_ff got %h exp 0000", inst); else passed++;
    endtask

    task automatic test_bad_hi();
        pulse_reload();
        total++; if (cpu_reset !== 1'b1) $display("FAIL badhi_reload_cpu_reset got %b exp 1", cpu_reset); else passed++;
        send(8'h01); send(8'h00); send(8'h20);
        total++; if (error !== 1'b1) $display("FAIL badhi_error got %b exp 1", error); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL badhi_in_ready got %b exp 0", in_ready); else passed++;
        in_data = 8'h77; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total++; if (error !== 1'b1) $display("FAIL badhi_sticky got %b exp 1", error); else passed++;
        total++; if (cpu_reset !== 1'b1) $display("FAIL badhi_cpu_reset got %b exp 1", cpu_reset); else passed++;
        total++; if (words_loaded !== 9'd0) $display("FAIL badhi_words got %0d exp 0", words_loaded); else passed++;
        pc = 8'h00; #1;
        total++; if (inst !== 13'h1234) $display("FAIL badhi_no_write got %h exp 1234", inst); else passed++;
    endtask

    task automatic test_checksum();
        int n;
        pulse_reload();
        send(8'h01); send(8'hAA); send(8'h05); send(8'hAE);
        total++; if (error !== 1'b0) $display("FAIL csum_ok_error got %b exp 0", error); else passed++;
        wait_done(n);
        total++; if (n !== 255) $display("FAIL csum_ok_fill got %0d exp 255", n); else passed++;
        pc = 8'h00; #1;
        total++; if (inst !== 13'h05AA) $display("FAIL csum_ok_fetch0 got %h exp 05aa", inst); else passed++;
        pc = 8'h01; #1;
        total++; if (inst !== 13'h0000) $display("FAIL csum_ok_fetch1 got %h exp 0000", inst); else passed++;
        pulse_reload();
        send(8'h01); send(8'hAA); send(8'h05); send(8'hC5);
        total++; if (error !== 1'b1) $display("FAIL csum_bad_error got %b exp 1", error); else passed++;
        total++; if (done !== 1'b0) $display("FAIL csum_bad_done got %b exp 0", done); else passed++;
    endtask

    task automatic test_full_256();
        logic [INST_W-1:0] w [DEPTH];
        logic [7:0] cs;
        pulse_reload();
        cs = 8'h00;
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            w[i] = INST_W'(i * 37 + 5);
            cs = cs ^ w[i][7:0] ^ {3'b000, w[i][12:8]};
            send(w[i][7:0]);
            send({3'b000, w[i][12:8]});
        end
        send(cs);
        total++; if (done !== 1'b1) $display("FAIL full_done got %b exp 1", done); else passed++;
        total++; if (cpu_reset !== 1'b0) $display("FAIL full_cpu_reset got %b exp 0", cpu_reset); else passed++;
        total++; if (words_loaded !== 9'd256) $display("FAIL full_words got %0d exp 256", words_loaded); else passed++;
        pc = 8'hFF; #1;
        total++; if (inst !== w[255]) $display("FAIL full_fetch_ff got %h exp %h", inst, w[255]); else passed++;
        pc = 8'h80; #1;
        total++; if (inst !== w[128]) $display("FAIL full_fetch_80 got %h exp %h", inst, w[128]); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] cs;
        pulse_reload();
        send(8'h02); send(8'h34); send(8'h12); send(8'hFF); send(8'h1F);
        in_data = 8'hC4; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h55;
        wait_done(n);
        total++; if (n !== 254) $display("FAIL hold_fill_cycles got %0d exp 254", n); else passed++;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL hold_run_in_ready got %b exp 0", in_ready); else passed++;
        total++; if (words_loaded !== 9'd2) $display("FAIL hold_run_words got %0d exp 2", words_loaded); else passed++;
        total++; if (done !== 1'b1) $display("FAIL hold_run_done got %b exp 1", done); else passed++;
        pulse_reload();
        total++; if (cpu_reset !== 1'b1) $display("FAIL reload_cpu_reset got %b exp 1", cpu_reset); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reload_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (words_loaded !== 9'd0) $display("FAIL reload_words got %0d exp 0", words_loaded); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        cs = 8'h55;
        for (int i = 0; i < 85; i++) begin
            cs = cs ^ 8'(i);
            send(8'(i));
            send(8'h00);
        end
        send(cs);
        total++; if (error !== 1'b0) $display("FAIL hdr55_error got %b exp 0", error); else passed++;
        total++; if (words_loaded !== 9'd85) $display("FAIL hdr55_words got %0d exp 85", words_loaded); else passed++;
        wait_done(n);
        total++; if (n !== 171) $display("FAIL hdr55_fill got %0d exp 171", n); else passed++;
        pc = 8'h54; #1;
        total++; if (inst !== 13'h0054) $display("FAIL hdr55_fetch54 got %h exp 0054", inst); else passed++;
        pc = 8'h55; #1;
        total++; if (inst !== 13'h0000) $display("FAIL hdr55_fetch55 got %h exp 0000", inst); else passed++;
    endtask

    task automatic test_reset_mid_load();
        int n;
        pulse_reload();
        send(8'h03); send(8'h11); send(8'h02); send(8'h33);
        total++; if (words_loaded !== 9'd1) $display("FAIL mid_words_pre got %0d exp 1", words_loaded); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (words_loaded !== 9'd0) $display("FAIL mid_rst_words got %0d exp 0", words_loaded); else passed++;
        total++; if (cpu_reset !== 1'b1) $display("FAIL mid_rst_cpu_reset got %b exp 1", cpu_reset); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (error !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_flags got err=%b done=%b exp 0 0", error, done); else passed++;
        pc = 8'h00; #1;
        total++; if (inst !== 13'h0211) $display("FAIL mid_rst_retained got %h exp 0211", inst); else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(8'h01); send(8'hAA); send(8'h05); send(8'hAE);
        wait_done(n);
        total++; if (n !== 255) $display("FAIL mid_fresh_fill got %0d exp 255", n); else passed++;
        pc = 8'h00; #1;
        total++; if (inst !== 13'h05AA) $display("FAIL mid_fresh_fetch0 got %h exp 05aa", inst); else passed++;
        pc = 8'h01; #1;
        total++; if (inst !== 13'h0000) $display("FAIL mid_fresh_fetch1 got %h exp 0000", inst); else passed++;
    endtask

    initial begin
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        pc       = '0;
        test_reset();
        test_fill_load();
        test_bad_hi();
        test_checksum();
        test_full_256();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
